// File: rtl/sync_frame_decoder_if.sv
// Strobe/index bus from sync_frame_decoder to the acquisition gating logic.
// The decoder drives the master modport and consumers attach to the slave modport.
`timescale 1ns/1ps
interface sync_frame_decoder_if #(
  parameter int IDX_W     = 9,
  parameter int LINE_NBIT = 8
);
  logic                 sample_stb;
  logic [IDX_W-1:0]     sample_idx;
  logic                 data_bit;
  logic                 line_stb;
  logic [LINE_NBIT-1:0] line_idx;
  logic                 frame_stb;
  logic                 locked;
  logic                 frame_locked;
  logic                 sync_err;
  logic                 timeout;

  modport master (
    output sample_stb, sample_idx, data_bit, line_stb, line_idx,
           frame_stb, locked, frame_locked, sync_err, timeout
  );

  modport slave (
    input  sample_stb, sample_idx, data_bit, line_stb, line_idx,
           frame_stb, locked, frame_locked, sync_err, timeout
  );
endinterface

// File: rtl/sync_frame_decoder.sv
// Receives the async sync / sample-clock / data link, locks to the line and frame
// structure and emits sample, line and frame strobes with their indices.
`timescale 1ns/1ps
module sync_frame_decoder #(
  parameter int SP_PER_LINE = 512,
  parameter int SYNC_LEN    = 9,
  parameter int GAP_LINES   = 5,
  parameter int MAX_MISS    = 8,
  parameter int LINE_NBIT   = 8,
  parameter int TIMEOUT     = 1024
) (
  input  logic                  mclk,
  input  logic                  rst,
  input  logic                  sync_i,
  input  logic                  spclk_i,
  input  logic                  data_i,
  sync_frame_decoder_if.master  dec
);
  localparam int IDX_W  = $clog2(SP_PER_LINE);
  localparam int WD_W   = $clog2(TIMEOUT);
  localparam int RUN_W  = $clog2(SYNC_LEN + 2);
  localparam int MISS_W = $clog2(MAX_MISS + 2);

  typedef enum logic [1:0] {HUNT = 2'd0, CHECK = 2'd1, TRACK = 2'd2} state_e;

  // Bit order in the synchroniser vectors: {data, spclk, sync}
  logic [2:0]           meta_q, meta_d, sync2_q, sync2_d, hist_q, hist_d;
  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [RUN_W-1:0]     run_q, run_d;
  logic [MISS_W-1:0]    miss_q, miss_d;
  logic [LINE_NBIT-1:0] line_idx_q, line_idx_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic                 prev_s_q, prev_s_d, win_ok_q, win_ok_d, win_zero_q, win_zero_d;
  logic                 sample_stb_q, sample_stb_d, data_bit_q, data_bit_d;
  logic                 line_stb_q, line_stb_d, frame_stb_q, frame_stb_d;
  logic                 locked_q, locked_d, frame_locked_q, frame_locked_d;
  logic                 sync_err_q, sync_err_d, timeout_q, timeout_d;

  logic                 sample_ev, s_smp, d_smp, wd_expire;
  logic [IDX_W-1:0]     idx_inc;

  assign sample_ev = sync2_q[1] & ~hist_q[1];
  assign s_smp     = sync2_q[0];
  assign d_smp     = sync2_q[2];
  assign wd_expire = (wd_q == WD_W'(TIMEOUT - 1));
  assign idx_inc   = (idx_q == IDX_W'(SP_PER_LINE - 1)) ? {IDX_W{1'b0}} : idx_q + 1'b1;
  assign meta_d    = {data_i, spclk_i, sync_i};
  assign sync2_d   = meta_q;
  assign hist_d    = sync2_q;

  // Next-state logic; a watchdog expiry masks any sample event in the same cycle
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    run_d          = run_q;
    miss_d         = miss_q;
    line_idx_d     = line_idx_q;
    wd_d           = wd_q + 1'b1;
    prev_s_d       = prev_s_q;
    win_ok_d       = win_ok_q;
    win_zero_d     = win_zero_q;
    data_bit_d     = data_bit_q;
    locked_d       = locked_q;
    frame_locked_d = frame_locked_q;
    sample_stb_d   = 1'b0;
    line_stb_d     = 1'b0;
    frame_stb_d    = 1'b0;
    sync_err_d     = 1'b0;
    timeout_d      = 1'b0;
    if (wd_expire) begin
      timeout_d      = 1'b1;
      wd_d           = {WD_W{1'b0}};
      state_d        = HUNT;
      locked_d       = 1'b0;
      frame_locked_d = 1'b0;
    end else if (sample_ev) begin
      wd_d         = {WD_W{1'b0}};
      sample_stb_d = 1'b1;
      data_bit_d   = d_smp;
      prev_s_d     = s_smp;
      case (state_q)
        HUNT: begin
          if (s_smp && !prev_s_q) begin
            idx_d   = {IDX_W{1'b0}};
            run_d   = RUN_W'(1);
            state_d = CHECK;
          end else begin
            state_d = HUNT;
          end
        end
        CHECK: begin
          idx_d = idx_q + 1'b1;
          if (s_smp) begin
            if (run_q >= RUN_W'(SYNC_LEN)) begin
              sync_err_d = 1'b1;
              state_d    = HUNT;
            end else begin
              run_d = run_q + 1'b1;
            end
          end else if (run_q == RUN_W'(SYNC_LEN)) begin
            state_d        = TRACK;
            locked_d       = 1'b1;
            frame_locked_d = 1'b0;
            miss_d         = {MISS_W{1'b0}};
          end else begin
            sync_err_d = 1'b1;
            state_d    = HUNT;
          end
        end
        TRACK: begin
          idx_d = idx_inc;
          // Window flags accumulate over samples 0..SYNC_LEN-1 and are judged at SYNC_LEN
          if (idx_inc == {IDX_W{1'b0}}) begin
            win_ok_d   = s_smp;
            win_zero_d = ~s_smp;
          end else if (idx_inc < IDX_W'(SYNC_LEN)) begin
            win_ok_d   = win_ok_q & s_smp;
            win_zero_d = win_zero_q & ~s_smp;
          end else if (idx_inc == IDX_W'(SYNC_LEN)) begin
            if (win_ok_q && !s_smp) begin
              line_stb_d = 1'b1;
              miss_d     = {MISS_W{1'b0}};
              if (miss_q >= MISS_W'(GAP_LINES)) begin
                frame_stb_d    = 1'b1;
                line_idx_d     = {LINE_NBIT{1'b0}};
                frame_locked_d = 1'b1;
              end else if (line_idx_q != {LINE_NBIT{1'b1}}) begin
                line_idx_d = line_idx_q + 1'b1;
              end else begin
                line_idx_d = line_idx_q;
              end
            end else if (win_zero_q && !s_smp) begin
              if (miss_q >= MISS_W'(MAX_MISS)) begin
                state_d        = HUNT;
                locked_d       = 1'b0;
                frame_locked_d = 1'b0;
              end else begin
                miss_d = miss_q + 1'b1;
              end
            end else begin
              sync_err_d     = 1'b1;
              state_d        = HUNT;
              locked_d       = 1'b0;
              frame_locked_d = 1'b0;
            end
          end else if (s_smp) begin
            sync_err_d     = 1'b1;
            state_d        = HUNT;
            locked_d       = 1'b0;
            frame_locked_d = 1'b0;
          end else begin
            state_d = TRACK;
          end
        end
        default: begin
          state_d        = HUNT;
          locked_d       = 1'b0;
          frame_locked_d = 1'b0;
        end
      endcase
    end else begin
      wd_d = wd_q + 1'b1;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge mclk) begin
    if (rst) begin
      meta_q         <= 3'b000;
      sync2_q        <= 3'b000;
      hist_q         <= 3'b000;
      state_q        <= HUNT;
      idx_q          <= {IDX_W{1'b0}};
      run_q          <= {RUN_W{1'b0}};
      miss_q         <= {MISS_W{1'b0}};
      line_idx_q     <= {LINE_NBIT{1'b0}};
      wd_q           <= {WD_W{1'b0}};
      prev_s_q       <= 1'b0;
      win_ok_q       <= 1'b0;
      win_zero_q     <= 1'b0;
      sample_stb_q   <= 1'b0;
      data_bit_q     <= 1'b0;
      line_stb_q     <= 1'b0;
      frame_stb_q    <= 1'b0;
      locked_q       <= 1'b0;
      frame_locked_q <= 1'b0;
      sync_err_q     <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      meta_q         <= meta_d;
      sync2_q        <= sync2_d;
      hist_q         <= hist_d;
      state_q        <= state_d;
      idx_q          <= idx_d;
      run_q          <= run_d;
      miss_q         <= miss_d;
      line_idx_q     <= line_idx_d;
      wd_q           <= wd_d;
      prev_s_q       <= prev_s_d;
      win_ok_q       <= win_ok_d;
      win_zero_q     <= win_zero_d;
      sample_stb_q   <= sample_stb_d;
      data_bit_q     <= data_bit_d;
      line_stb_q     <= line_stb_d;
      frame_stb_q    <= frame_stb_d;
      locked_q       <= locked_d;
      frame_locked_q <= frame_locked_d;
      sync_err_q     <= sync_err_d;
      timeout_q      <= timeout_d;
    end
  end

  assign dec.sample_stb   = sample_stb_q;
  assign dec.sample_idx   = idx_q;
  assign dec.data_bit     = data_bit_q;
  assign dec.line_stb     = line_stb_q;
  assign dec.line_idx     = line_idx_q;
  assign dec.frame_stb    = frame_stb_q;
  assign dec.locked       = locked_q;
  assign dec.frame_locked = frame_locked_q;
  assign dec.sync_err     = sync_err_q;
  assign dec.timeout      = timeout_q;
endmodule
